// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared types and constants for the clock frequency/duty meter.
//   state_t   : measurement FSM states
//   DUTY_W    : width of the duty-cycle percentage result
//   PCT_SCALE : duty numerator scale (percent)
//   DIV_ITER  : quotient bits produced by the divider, one per cycle
package clk_meas_pkg;
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DIVIDE} state_t;
   localparam int DUTY_W    = 7;
   localparam int PCT_SCALE = 100;
   localparam int DIV_ITER  = 7;
endpackage

// File: rtl/duty_div.sv
// duty_div: sequential restoring divider producing a 7-bit quotient, MSB first.
//   clk, rst_n : clock, async active-low reset
//   start      : load num/den and begin (ignored while abort is high)
//   abort      : drop any in-flight division
//   num        : dividend, must satisfy num < den*128
//   den        : divisor, non-zero
//   busy       : division in progress
//   done       : last iteration this cycle; quot is valid only now
//   quot       : quotient
module duty_div
   import clk_meas_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [CNT_W+DUTY_W-1:0] num,
   input  logic [CNT_W-1:0]        den,
   output logic                    busy,
   output logic                    done,
   output logic [DUTY_W-1:0]       quot
);
   localparam int NW = CNT_W + DUTY_W;

   logic [NW-1:0]     r_rem;
   logic [CNT_W-1:0]  r_den;
   logic [DUTY_W-2:0] r_q;
   logic [2:0]        r_k;
   logic              r_busy;
   logic [NW-1:0]     w_trial;
   logic              w_ge;

   assign w_trial = NW'(r_den) << r_k;
   assign w_ge    = r_rem >= w_trial;
   assign busy    = r_busy;
   assign done    = r_busy && r_k == 3'd0;
   // final quotient bit is taken combinationally so the result is ready in the done cycle
   assign quot    = {r_q, w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_den  <= '0;
         r_q    <= '0;
         r_k    <= '0;
         r_busy <= 1'b0;
      end else if (abort) begin
         r_busy <= 1'b0;
      end else if (start) begin
         r_rem  <= num;
         r_den  <= den;
         r_q    <= '0;
         r_k    <= 3'(DIV_ITER - 1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_rem  <= w_ge ? r_rem - w_trial : r_rem;
         r_q    <= {r_q[DUTY_W-3:0], w_ge};
         r_k    <= r_k - 3'd1;
         r_busy <= r_k != 3'd0;
      end
   end
endmodule

// File: rtl/clk_freq_duty_meter.sv
// clk_freq_duty_meter: measures period, high time and duty of meas_clk in clk cycles.
//   clk, rst_n : local clock, async active-low reset
//   en         : measurement enable (level)
//   meas_clk   : clock under test, asynchronous
//   period_cnt : last measured period
//   high_cnt   : last measured high time
//   duty_pct   : floor(high_cnt*100/period_cnt)
//   meas_valid : one-cycle strobe, results update with it
//   overrun    : one-cycle strobe, a period was discarded during a divide
//   stuck      : no rise seen for 2^CNT_W-1 cycles
module clk_freq_duty_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              meas_clk,
   output logic [CNT_W-1:0]  period_cnt,
   output logic [CNT_W-1:0]  high_cnt,
   output logic [DUTY_W-1:0] duty_pct,
   output logic              meas_valid,
   output logic              overrun,
   output logic              stuck
);
   localparam logic [CNT_W-1:0] MAX = '1;

   logic [SYNC_STAGES-1:0]    r_sync;
   logic                      r_s_d;
   state_t                    r_state, w_next;
   logic [CNT_W-1:0]          r_pcnt, r_hcnt, r_p, r_h;
   logic [CNT_W-1:0]          r_period, r_high;
   logic [DUTY_W-1:0]         r_duty, w_quot;
   logic                      r_valid, r_ovr, r_stuck;
   logic                      w_s, w_rise, w_sat, w_start, w_done, w_busy, w_fin;
   logic [CNT_W+DUTY_W-1:0]   w_num;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_rise = w_s & ~r_s_d;
   // saturation without a rendering rise means the clock is considered dead
   assign w_sat  = en && r_state != IDLE && r_pcnt == MAX && !w_rise;
   assign w_fin  = en && r_state == DIVIDE && w_done;
   assign w_num  = (CNT_W+DUTY_W)'(r_hcnt) * (CNT_W+DUTY_W)'(PCT_SCALE);

   assign period_cnt = r_period;
   assign high_cnt   = r_high;
   assign duty_pct   = r_duty;
   assign meas_valid = r_valid;
   assign overrun    = r_ovr;
   assign stuck      = r_stuck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], meas_clk};
         r_s_d  <= w_s;
      end
   end

   // counters keep running in every enabled state so overlap and stuck detection work
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
         r_hcnt <= '0;
      end else if (!en || r_state == IDLE) begin
         r_pcnt <= '0;
         r_hcnt <= '0;
      end else if (w_rise) begin
         r_pcnt <= CNT_W'(1);
         r_hcnt <= CNT_W'(w_s);
      end else begin
         r_pcnt <= r_pcnt == MAX ? r_pcnt : r_pcnt + CNT_W'(1);
         r_hcnt <= (w_s && r_hcnt != MAX) ? r_hcnt + CNT_W'(1) : r_hcnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      case (r_state)
         IDLE:    w_next = ARM;
         ARM:     w_next = w_rise ? MEASURE : ARM;
         MEASURE: begin
            if (w_rise) begin
               w_next  = DIVIDE;
               w_start = 1'b1;
            end else if (w_sat) begin
               w_next = ARM;
            end
         end
         DIVIDE:  w_next = (w_done || !w_busy) ? MEASURE : DIVIDE;
         default: w_next = IDLE;
      endcase
      if (!en) begin
         w_next  = IDLE;
         w_start = 1'b0;
      end
   end

   duty_div #(.CNT_W(CNT_W)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_start),
      .abort (!en),
      .num   (w_num),
      .den   (r_pcnt),
      .busy  (w_busy),
      .done  (w_done),
      .quot  (w_quot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p      <= '0;
         r_h      <= '0;
         r_period <= '0;
         r_high   <= '0;
         r_duty   <= '0;
         r_valid  <= 1'b0;
         r_ovr    <= 1'b0;
         r_stuck  <= 1'b0;
      end else begin
         if (w_start) begin
            r_p <= r_pcnt;
            r_h <= r_hcnt;
         end
         if (w_fin) begin
            r_period <= r_p;
            r_high   <= r_h;
            r_duty   <= w_quot;
         end
         r_valid <= w_fin;
         r_ovr   <= en && r_state == DIVIDE && w_rise;
         r_stuck <= (en && w_rise) ? 1'b0 : (w_sat ? 1'b1 : r_stuck);
      end
   end
endmodule

// File: tb/tb_clk_freq_duty_meter.sv
// tb_clk_freq_duty_meter: scoreboard bench for clk_freq_duty_meter with CNT_W=8.
module tb_clk_freq_duty_meter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       meas_clk = 1'b0;
   logic [7:0] period_cnt, high_cnt;
   logic [6:0] duty_pct;
   logic       meas_valid, overrun, stuck;

   typedef struct {int p; int h; int d; int cyc;} exp_t;
   exp_t q[$];
   int   oq[$];
   exp_t e;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   have_prev = 0;
   int   prev_p, prev_h, prev_d;

   clk_freq_duty_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .meas_clk   (meas_clk),
      .period_cnt (period_cnt),
      .high_cnt   (high_cnt),
      .duty_pct   (duty_pct),
      .meas_valid (meas_valid),
      .overrun    (overrun),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // one meas_clk period starting with a rise now; the rise completes the previous period,
   // which either yields a result 10 edges later or (ovr) an overrun pulse 3 edges later
   task automatic period(input int p, input int h, input int d, input bit ovr);
      if (have_prev) begin
         if (ovr) oq.push_back(cyc + 3);
         else q.push_back('{prev_p, prev_h, prev_d, cyc + 10});
      end
      prev_p = p;
      prev_h = h;
      prev_d = d;
      have_prev = 1;
      meas_clk = 1'b1;
      repeat (h) @(negedge clk);
      meas_clk = 1'b0;
      repeat (p - h) @(negedge clk);
   endtask

   task automatic chk_out(input string nm, input int p, input int h, input int d);
      chk({nm, "_period"}, period_cnt, p);
      chk({nm, "_high"}, high_cnt, h);
      chk({nm, "_duty"}, duty_pct, d);
   endtask

   always @(negedge clk) begin
      if (meas_valid) begin
         if (q.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            e = q.pop_front();
            chk("res_period", period_cnt, e.p);
            chk("res_high", high_cnt, e.h);
            chk("res_duty", duty_pct, e.d);
            chk("res_latency", cyc, e.cyc);
         end
      end
      if (overrun) begin
         if (oq.size() == 0) chk("unexpected_overrun", 1, 0);
         else chk("overrun_latency", cyc, oq.pop_front());
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_out("reset", 0, 0, 0);
      chk("reset_valid", meas_valid, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_stuck", stuck, 0);
      rst_n = 1'b1;
      @(negedge clk);
      en = 1'b1;
      repeat (2) @(negedge clk);
      repeat (6) period(10, 6, 60, 0);
      repeat (4) period(20, 10, 50, 0);
      repeat (3) period(40, 10, 25, 0);
      repeat (217) @(negedge clk);
      chk("stuck_early", stuck, 0);
      @(negedge clk);
      chk("stuck_set", stuck, 1);
      chk_out("stuck_hold", 40, 10, 25);
      have_prev = 0;
      period(10, 6, 60, 0);
      chk("stuck_clear", stuck, 0);
      repeat (2) period(10, 6, 60, 0);
      meas_clk = 1'b1;
      repeat (5) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      meas_clk = 1'b0;
      repeat (4) @(negedge clk);
      repeat (5) @(negedge clk);
      chk_out("abort_hold", 10, 6, 60);
      have_prev = 0;
      en = 1'b1;
      repeat (2) @(negedge clk);
      repeat (3) period(10, 6, 60, 0);
      for (int i = 0; i < 6; i++) period(6, 3, 50, i[0]);
      repeat (4) period(8, 2, 25, 0);
      meas_clk = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_out("async_reset", 0, 0, 0);
      chk("async_reset_valid", meas_valid, 0);
      chk("async_reset_overrun", overrun, 0);
      chk("async_reset_stuck", stuck, 0);
      @(negedge clk);
      meas_clk = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      have_prev = 0;
      repeat (3) period(10, 6, 60, 0);
      repeat (20) @(negedge clk);
      chk("results_drained", q.size(), 0);
      chk("overruns_drained", oq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
